// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// MemoryController length/sign encodings and the fixed fetch request length.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  localparam logic [2:0] LEN_BYTE  = 3'b000;
  localparam logic [2:0] LEN_HALF  = 3'b001;
  localparam logic [2:0] LEN_WORD  = 3'b010;
  localparam logic [2:0] LEN_SIGN  = 3'b100;
  localparam logic [2:0] FETCH_LEN = LEN_WORD;

  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data requests win, fetch is forced after
// STARVE_LIMIT consecutive data grants, and a flush drains an in-flight fetch.
//
// Handshakes: inst_valid/data_valid are levels held by the requester until its
// one-cycle ready pulse; mc_valid is a level held until the one-cycle mc_ready.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        inst_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_res,
  input  logic        data_valid,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_value,
  output logic        data_ready,
  output logic [31:0] data_res,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_data,
  input  logic        mc_ready,
  input  logic [31:0] mc_res,
  output arb_state_t  dbg_state,
  output logic [CNT_W-1:0] dbg_count
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic fetch_starved;
  assign fetch_starved = inst_valid && (count_q == LIMIT);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // With rdy_in low both registers simply hold their value.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (!inst_valid) begin
            count_d = '0;
          end
          if (data_valid && !fetch_starved) begin
            state_d = BUSY_D;
            if (inst_valid) begin
              count_d = sat_inc(count_q);
            end
          end else if (inst_valid && !flush) begin
            state_d = BUSY_I;
            count_d = '0;
          end
        end
        BUSY_I: begin
          if (mc_ready) begin
            state_d = IDLE;
          end else if (flush) begin
            state_d = DRAIN;
          end
        end
        BUSY_D: begin
          if (mc_ready) begin
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (mc_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // DRAIN keeps presenting the fetch request so the controller sees stable fields.
  always_comb begin
    mc_valid   = (state_q != IDLE);
    mc_data    = data_value;
    mc_wr      = data_wr;
    mc_addr    = data_addr;
    mc_len     = data_size;
    inst_ready = 1'b0;
    data_ready = 1'b0;
    inst_res   = mc_res;
    data_res   = mc_res;
    if (state_q == BUSY_I || state_q == DRAIN) begin
      mc_wr   = 1'b0;
      mc_addr = inst_addr;
      mc_len  = FETCH_LEN;
    end
    if (rdy_in) begin
      inst_ready = (state_q == BUSY_I) && mc_ready && !flush;
      data_ready = (state_q == BUSY_D) && mc_ready;
    end
  end

  assign dbg_state = state_q;
  assign dbg_count = count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of IDLE arbitration vectors plus
// hand-written sequences for fetch, contention, starvation, flush, freeze, reset.
module tb_mem_arbiter;
  import cpu_mem_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        data_valid = 1'b0;
  logic        data_wr = 1'b0;
  logic [2:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_value = '0;
  logic        data_ready;
  logic [31:0] data_res;
  logic        mc_valid;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic [31:0] mc_data;
  logic        mc_ready = 1'b0;
  logic [31:0] mc_res = '0;
  arb_state_t  dbg_state;
  logic [3:0]  dbg_count;

  int n_cmp = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .inst_valid(inst_valid), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .inst_res(inst_res),
    .data_valid(data_valid), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_value(data_value),
    .data_ready(data_ready), .data_res(data_res),
    .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_data(mc_data), .mc_ready(mc_ready), .mc_res(mc_res),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  always #5 clk_in = ~clk_in;

  // Requesters must hold valid for the whole of their own transaction.
  always @(posedge clk_in) begin
    if (rst_in && dbg_state == BUSY_D)
      assert (data_valid) else $error("data requester dropped valid mid-transaction");
    if (rst_in && dbg_state == BUSY_I)
      assert (inst_valid) else $error("fetch requester dropped valid mid-transaction");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv, dv, wr, fl;
    logic [2:0]  size;
    logic [31:0] daddr;
    arb_state_t  exp_st;
    logic        exp_mv, exp_wr;
    logic [31:0] exp_addr;
    logic [2:0]  exp_len;
    logic [3:0]  exp_cnt;
    logic        exp_ir, exp_dr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h10, IDLE,   1'b0, 1'b0, 32'h10,   3'b010, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 32'h20, IDLE,   1'b0, 1'b1, 32'h20,   3'b001, 4'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h30, BUSY_I, 1'b1, 1'b0, 32'h1000, 3'b010, 4'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 32'h40, BUSY_D, 1'b1, 1'b0, 32'h40,   3'b100, 4'd0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 32'h50, BUSY_D, 1'b1, 1'b1, 32'h50,   3'b001, 4'd0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h60, BUSY_D, 1'b1, 1'b0, 32'h60,   3'b101, 4'd1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h70, BUSY_D, 1'b1, 1'b1, 32'h70,   3'b010, 4'd0, 1'b0, 1'b1};

    // Reset state
    #2;
    check("rst_mc_valid", 32'(mc_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_count", 32'(dbg_count), 32'd0);
    tick();
    rst_in = 1'b1;
    tick();

    // IDLE arbitration table, each vector starting from IDLE with count 0
    inst_addr = 32'h1000;
    for (int i = 0; i < 7; i++) begin
      inst_valid = vecs[i].iv;
      data_valid = vecs[i].dv;
      data_wr    = vecs[i].wr;
      flush      = vecs[i].fl;
      data_size  = vecs[i].size;
      data_addr  = vecs[i].daddr;
      data_value = 32'h5000 + 32'(i);
      tick();
      check($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].exp_st));
      check($sformatf("v%0d_mc_valid", i), 32'(mc_valid), 32'(vecs[i].exp_mv));
      check($sformatf("v%0d_mc_wr", i), 32'(mc_wr), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_mc_addr", i), mc_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_mc_len", i), 32'(mc_len), 32'(vecs[i].exp_len));
      check($sformatf("v%0d_mc_data", i), mc_data, 32'h5000 + 32'(i));
      check($sformatf("v%0d_count", i), 32'(dbg_count), 32'(vecs[i].exp_cnt));
      flush = 1'b0;
      if (vecs[i].exp_st != IDLE) begin
        mc_ready = 1'b1;
        mc_res   = 32'hA5A50000 + 32'(i);
        #1;
        check($sformatf("v%0d_inst_ready", i), 32'(inst_ready), 32'(vecs[i].exp_ir));
        check($sformatf("v%0d_data_ready", i), 32'(data_ready), 32'(vecs[i].exp_dr));
        if (vecs[i].exp_dr)
          check($sformatf("v%0d_data_res", i), data_res, 32'hA5A50000 + 32'(i));
        tick();
        mc_ready = 1'b0;
      end
      inst_valid = 1'b0;
      data_valid = 1'b0;
      tick();
      check($sformatf("v%0d_back_idle", i), 32'(dbg_state), 32'(IDLE));
    end

    // Fetch only, completion after 4 cycles, bubble, next grant
    inst_valid = 1'b1;
    inst_addr  = 32'h100;
    tick();
    check("fetch_mc_valid", 32'(mc_valid), 32'd1);
    check("fetch_mc_addr", mc_addr, 32'h100);
    check("fetch_mc_len", 32'(mc_len), 32'd2);
    repeat (3) tick();
    check("fetch_wait_ready", 32'(inst_ready), 32'd0);
    mc_ready = 1'b1;
    mc_res   = 32'hDEADBEEF;
    #1;
    check("fetch_inst_ready", 32'(inst_ready), 32'd1);
    check("fetch_inst_res", inst_res, 32'hDEADBEEF);
    tick();
    mc_ready  = 1'b0;
    inst_addr = 32'h104;
    check("fetch_bubble", 32'(mc_valid), 32'd0);
    tick();
    check("fetch_next_grant", 32'(mc_valid), 32'd1);
    check("fetch_next_addr", mc_addr, 32'h104);
    mc_ready = 1'b1;
    tick();
    mc_ready   = 1'b0;
    inst_valid = 1'b0;
    tick();

    // Contention: store wins, then the fetch
    inst_valid = 1'b1;
    inst_addr  = 32'h180;
    data_valid = 1'b1;
    data_wr    = 1'b1;
    data_size  = LEN_WORD;
    data_addr  = 32'h2000;
    data_value = 32'h12345678;
    tick();
    check("cont_state", 32'(dbg_state), 32'(BUSY_D));
    check("cont_mc_wr", 32'(mc_wr), 32'd1);
    check("cont_mc_addr", mc_addr, 32'h2000);
    check("cont_mc_data", mc_data, 32'h12345678);
    mc_ready = 1'b1;
    #1;
    check("cont_data_ready", 32'(data_ready), 32'd1);
    tick();
    mc_ready   = 1'b0;
    data_valid = 1'b0;
    tick();
    check("cont_fetch_state", 32'(dbg_state), 32'(BUSY_I));
    check("cont_fetch_addr", mc_addr, 32'h180);
    mc_ready = 1'b1;
    tick();
    mc_ready   = 1'b0;
    inst_valid = 1'b0;
    tick();

    // Starvation: four data grants with fetch pending, then fetch forced
    inst_valid = 1'b1;
    inst_addr  = 32'h200;
    data_valid = 1'b1;
    data_wr    = 1'b0;
    data_addr  = 32'h3000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("starve%0d_state", k), 32'(dbg_state), 32'(BUSY_D));
      check($sformatf("starve%0d_count", k), 32'(dbg_count), 32'(k));
      mc_ready = 1'b1;
      tick();
      mc_ready = 1'b0;
      check($sformatf("starve%0d_bubble", k), 32'(mc_valid), 32'd0);
    end
    tick();
    check("starve_fetch_state", 32'(dbg_state), 32'(BUSY_I));
    check("starve_fetch_addr", mc_addr, 32'h200);
    check("starve_count_clr", 32'(dbg_count), 32'd0);
    mc_ready = 1'b1;
    tick();
    mc_ready   = 1'b0;
    inst_valid = 1'b0;
    data_valid = 1'b0;
    tick();

    // Flush two cycles into BUSY_I drains without inst_ready
    inst_valid = 1'b1;
    inst_addr  = 32'h300;
    tick();
    tick();
    flush = 1'b1;
    #1;
    check("flush_no_ready", 32'(inst_ready), 32'd0);
    tick();
    flush      = 1'b0;
    inst_valid = 1'b0;
    check("flush_drain", 32'(dbg_state), 32'(DRAIN));
    check("flush_drain_valid", 32'(mc_valid), 32'd1);
    check("flush_drain_addr", mc_addr, 32'h300);
    tick();
    check("flush_drain_hold", 32'(dbg_state), 32'(DRAIN));
    mc_ready = 1'b1;
    mc_res   = 32'h0BADF00D;
    #1;
    check("drain_inst_ready", 32'(inst_ready), 32'd0);
    tick();
    mc_ready = 1'b0;
    check("drain_done_idle", 32'(mc_valid), 32'd0);
    data_valid = 1'b1;
    data_wr    = 1'b0;
    data_addr  = 32'h400;
    tick();
    check("after_drain_grant", 32'(dbg_state), 32'(BUSY_D));
    mc_ready = 1'b1;
    mc_res   = 32'h44443333;
    #1;
    check("after_drain_res", data_res, 32'h44443333);
    tick();
    mc_ready   = 1'b0;
    data_valid = 1'b0;
    tick();

    // Flush and mc_ready together in BUSY_I
    inst_valid = 1'b1;
    inst_addr  = 32'h500;
    tick();
    flush    = 1'b1;
    mc_ready = 1'b1;
    #1;
    check("flushrdy_inst_ready", 32'(inst_ready), 32'd0);
    tick();
    flush      = 1'b0;
    mc_ready   = 1'b0;
    inst_valid = 1'b0;
    check("flushrdy_idle", 32'(dbg_state), 32'(IDLE));
    tick();

    // rdy_in low for three cycles mid-BUSY_D
    data_valid = 1'b1;
    data_addr  = 32'h600;
    tick();
    rdy_in = 1'b0;
    tick();
    mc_ready = 1'b1;
    #1;
    check("frz_data_ready", 32'(data_ready), 32'd0);
    tick();
    mc_ready = 1'b0;
    tick();
    check("frz_state", 32'(dbg_state), 32'(BUSY_D));
    check("frz_mc_valid", 32'(mc_valid), 32'd1);
    check("frz_mc_addr", mc_addr, 32'h600);
    rdy_in   = 1'b1;
    mc_ready = 1'b1;
    mc_res   = 32'hCAFEF00D;
    #1;
    check("frz_done_ready", 32'(data_ready), 32'd1);
    check("frz_done_res", data_res, 32'hCAFEF00D);
    tick();
    mc_ready = 1'b0;
    check("frz_idle", 32'(dbg_state), 32'(IDLE));
    data_valid = 1'b0;
    tick();

    // Asynchronous reset mid-BUSY_D, then re-grant of the held request
    data_valid = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h700;
    tick();
    check("arst_busy", 32'(dbg_state), 32'(BUSY_D));
    #1;
    rst_in = 1'b0;
    #1;
    check("arst_mc_valid", 32'(mc_valid), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst_in = 1'b1;
    tick();
    check("arst_regrant", 32'(dbg_state), 32'(BUSY_D));
    check("arst_regrant_addr", mc_addr, 32'h700);
    mc_ready = 1'b1;
    tick();
    mc_ready   = 1'b0;
    data_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
